tone_decoder: RTL and testbench
===============================

Name: tone_decoder

Overview:
- Receive-side counterpart of the tone generator. Measures the half-period of a square-wave tone on a single input pin and decodes it back into the (octave, note) pair that produced it.
- Used for loopback self-test of the piano and to recognise notes from an external square-wave source.
- Sits between the board pin (through an in-block synchronizer) and the piano display/control logic.

Parameters:
- TOL_SHIFT, 6, match tolerance is nominal >> TOL_SHIFT (about 1.56%).
- STABLE_COUNT, 2, number of consecutive identical matches required before outputs update.
- TIMEOUT, 4000000, cycles without an edge before the tone is declared absent.
- MIN_HALF, 64, measurements below this count are rejected as glitches.

Ports:
- clk_100M  in  1  100 MHz system clock.
- rst_n  in  1  asynchronous, active-low reset.
- tone_in  in  1  asynchronous square-wave tone input.
- octave  out  3  decoded octave, 0..7.
- note  out  3  decoded note: 0 = none, 1..7 = C..B.
- valid  out  1  high while a decoded tone is held.
- new_note  out  1  one-cycle pulse when the octave/note outputs change, or when valid rises.

Behaviour:
- One clock domain, clk_100M; rst_n is asynchronous and active-low. During reset: octave=0, note=0, valid=0, new_note=0, all internal state cleared.
- Input path: 2-FF synchronizer, then a third flop. Edge = sync2 ^ sync3; both rising and falling edges count.
- Period counter: on an edge, the counter loads 1; otherwise it increments each cycle. The measured half-period H is the counter value on the cycle the edge is seen. A source that toggles every M cycles gives H = M exactly.
- The first edge after reset or after a timeout only arms the counter; no measurement is taken.
- Timeout: counter saturates at TIMEOUT. On reaching it: valid=0, note=0, octave=0, stability state cleared, re-arm for a first edge. new_note does not pulse.
- Note table: C 3057805, D 2724194, E 2426982, F 2290765, G 2040840, A 1818182, B 1619816. Nominal(o,n) = base[n] >> o, 32-bit unsigned.
- A candidate matches when |H - nominal| <= nominal >> TOL_SHIFT.
- FSM states:
  - S_IDLE: on a valid measurement with H >= MIN_HALF, latch H and go to S_SEARCH. If H < MIN_HALF, treat as a miss and stay in S_IDLE.
  - S_SEARCH: test one candidate per cycle. Order: octave 0..7 outer, note 1..7 inner, 56 cycles maximum. First match goes to S_MATCH; exhaustion goes to S_MISS.
  - S_MATCH (1 cycle):
    - If the match equals the stored candidate, stable_cnt++ (saturating). Otherwise store the new candidate and set stable_cnt=1.
    - If stable_cnt reaches STABLE_COUNT: commit octave/note and set valid=1. Pulse new_note in the same cycle only if the value differs from the current outputs or valid was 0.
    - Return to S_IDLE.
  - S_MISS (1 cycle): candidate cleared, stable_cnt=0, outputs held. Return to S_IDLE.
- An edge arriving while not in S_IDLE still restarts the counter, but its measurement is discarded.
- Worst-case decode latency: STABLE_COUNT measurements + 58 cycles + 3 sync cycles.
- Reset asserted mid-search aborts immediately; no partial commit.
- Tolerance windows do not overlap: the smallest adjacent gap (E/F, B/next C) is about 5.6%.

Decomposition:
- Shared package piano_pkg:
  - note base-period constants (this table is the same one the generator uses and is shared with it);
  - NOTE_NONE = 0;
  - note/octave widths;
  - FSM state enum.
- Sub-module tone_period_meter: synchronizer, edge detect, period counter, first-edge arming, timeout. Outputs meas_valid, meas_h, timeout_pulse.
- tone_decoder itself contains the search FSM, stability logic and output registers.

Test Plan:
- A4, toggling every 113636 cycles (1818182 >> 4): after the arming edge plus 2 measurements, octave=4, note=6, valid=1, exactly one new_note pulse. Further edges produce no more pulses.
- Toggle every 114772 (+1%): still decodes A4. Toggle every 118000 (+3.8%): miss each time, outputs hold A4, valid stays 1.
- Switch from A4 to C5, toggling every 95556: after 2 measurements octave=5, note=1, one new_note pulse. A single stray C5 half-period between A4 half-periods causes no output change.
- Stop toggling: TIMEOUT = 4000000 cycles after the last edge, valid=0, note=0, octave=0, no new_note. Restarting A4 decodes again after the arming edge plus 2 measurements.
- Glitch pulse with H = 50 inside an A4 stream: rejected. stable_cnt resets, outputs stay A4, and the next 2 good measurements keep A4 with no pulse.
- Assert rst_n low during S_SEARCH: outputs go to 0 asynchronously. After release, the first edge only arms; decode needs the full arming edge plus 2 measurements.

Source files
------------

// File: rtl/piano_pkg.sv
// piano_pkg: note period table, widths and decoder state shared by the piano tone blocks.
package piano_pkg;
    localparam int OCT_W  = 3;
    localparam int NOTE_W = 3;
    localparam logic [NOTE_W-1:0] NOTE_NONE = '0;
    // Index 1..7 = C..B half-periods of octave 0 in clk_100M cycles; index 0 unused.
    localparam logic [7:0][31:0] NOTE_BASE = {
        32'd1619816, 32'd1818182, 32'd2040840, 32'd2290765,
        32'd2426982, 32'd2724194, 32'd3057805, 32'd0
    };
    typedef enum logic [1:0] {S_IDLE, S_SEARCH, S_MATCH, S_MISS} dec_state_t;
    function automatic logic [31:0] nominal(input logic [OCT_W-1:0] oct, input logic [NOTE_W-1:0] n,
                                            input int unsigned scale);
        return (NOTE_BASE[n] >> oct) >> scale;
    endfunction
endpackage

// File: rtl/tone_decoder_if.sv
// tone_decoder_if: decoded note outputs from the tone decoder to display/control logic.
interface tone_decoder_if;
    import piano_pkg::*;
    logic [OCT_W-1:0]  octave;
    logic [NOTE_W-1:0] note;
    logic              valid;
    logic              new_note;
    modport master(output octave, note, valid, new_note);
    modport slave(input octave, note, valid, new_note);
endinterface

// File: rtl/tone_period_meter.sv
// tone_period_meter: synchronizes tone_in and measures half-periods between edges, with timeout.
module tone_period_meter #(
    parameter int unsigned TIMEOUT = 4000000
) (
    input  logic        clk_100M,
    input  logic        rst_n,
    input  logic        tone_in,
    output logic        meas_valid,
    output logic [31:0] meas_h,
    output logic        timeout_pulse
);
    logic [2:0]  sync;
    logic [31:0] cnt;
    logic        armed;
    logic        edge_det;
    assign edge_det      = sync[1] ^ sync[2];
    assign meas_valid    = edge_det & armed;
    assign meas_h        = cnt;
    assign timeout_pulse = armed & ~edge_det & (cnt == 32'(TIMEOUT));
    // The first edge after reset or timeout only arms; later edges deliver a measurement.
    always_ff @(posedge clk_100M or negedge rst_n) begin
        if (!rst_n) begin
            sync  <= '0;
            cnt   <= '0;
            armed <= 1'b0;
        end else begin
            sync  <= {sync[1:0], tone_in};
            cnt   <= edge_det ? 32'd1 : (cnt == 32'(TIMEOUT) ? cnt : cnt + 32'd1);
            armed <= edge_det | (armed & ~timeout_pulse);
        end
    end
endmodule

// File: rtl/tone_decoder.sv
// tone_decoder: decodes a measured square-wave half-period into a stable (octave, note) pair.
module tone_decoder
    import piano_pkg::*;
#(
    parameter int unsigned TOL_SHIFT    = 6,
    parameter int unsigned STABLE_COUNT = 2,
    parameter int unsigned TIMEOUT      = 4000000,
    parameter int unsigned MIN_HALF     = 64,
    parameter int unsigned SCALE_SHIFT  = 0
) (
    input  logic           clk_100M,
    input  logic           rst_n,
    input  logic           tone_in,
    tone_decoder_if.master bus
);
    localparam int SW = $clog2(STABLE_COUNT + 1);
    logic              meas_valid, timeout_pulse;
    logic [31:0]       meas_h;
    dec_state_t        state, state_d;
    logic [31:0]       h_q, h_d, nom, diff;
    logic [OCT_W-1:0]  oi, oi_d, cand_oct, cand_oct_d, oct_d;
    logic [NOTE_W-1:0] ni, ni_d, cand_note, cand_note_d, note_d;
    logic [SW-1:0]     stable, stable_d, stable_inc;
    logic              valid_d, new_d, match, last;

    tone_period_meter #(.TIMEOUT(TIMEOUT)) u_meter (
        .clk_100M     (clk_100M),
        .rst_n        (rst_n),
        .tone_in      (tone_in),
        .meas_valid   (meas_valid),
        .meas_h       (meas_h),
        .timeout_pulse(timeout_pulse)
    );

    assign nom   = nominal(oi, ni, SCALE_SHIFT);
    assign diff  = h_q >= nom ? h_q - nom : nom - h_q;
    assign match = diff <= (nom >> TOL_SHIFT);
    assign last  = oi == 3'd7 && ni == 3'd7;
    // A cleared candidate has note 0, so it never equals a searched candidate.
    assign stable_inc = (cand_oct == oi && cand_note == ni)
                      ? (stable == SW'(STABLE_COUNT) ? stable : stable + 1'b1) : SW'(1);

    always_ff @(posedge clk_100M or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            h_q          <= '0;
            oi           <= '0;
            ni           <= '0;
            cand_oct     <= '0;
            cand_note    <= NOTE_NONE;
            stable       <= '0;
            bus.octave   <= '0;
            bus.note     <= NOTE_NONE;
            bus.valid    <= 1'b0;
            bus.new_note <= 1'b0;
        end else begin
            state        <= state_d;
            h_q          <= h_d;
            oi           <= oi_d;
            ni           <= ni_d;
            cand_oct     <= cand_oct_d;
            cand_note    <= cand_note_d;
            stable       <= stable_d;
            bus.octave   <= oct_d;
            bus.note     <= note_d;
            bus.valid    <= valid_d;
            bus.new_note <= new_d;
        end
    end

    always_comb begin
        state_d     = state;
        h_d         = h_q;
        oi_d        = oi;
        ni_d        = ni;
        cand_oct_d  = cand_oct;
        cand_note_d = cand_note;
        stable_d    = stable;
        oct_d       = bus.octave;
        note_d      = bus.note;
        valid_d     = bus.valid;
        new_d       = 1'b0;
        case (state)
            S_IDLE: begin
                if (meas_valid && meas_h >= 32'(MIN_HALF)) begin
                    h_d     = meas_h;
                    oi_d    = '0;
                    ni_d    = 3'd1;
                    state_d = S_SEARCH;
                end else if (meas_valid) begin
                    cand_oct_d  = '0;
                    cand_note_d = NOTE_NONE;
                    stable_d    = '0;
                end
            end
            S_SEARCH: begin
                state_d = match ? S_MATCH : (last ? S_MISS : S_SEARCH);
                if (!match && !last) begin
                    ni_d = ni == 3'd7 ? 3'd1 : ni + 3'd1;
                    oi_d = ni == 3'd7 ? oi + 3'd1 : oi;
                end
            end
            S_MATCH: begin
                cand_oct_d  = oi;
                cand_note_d = ni;
                stable_d    = stable_inc;
                if (stable_inc >= SW'(STABLE_COUNT)) begin
                    oct_d   = oi;
                    note_d  = ni;
                    valid_d = 1'b1;
                    new_d   = !bus.valid || oi != bus.octave || ni != bus.note;
                end
                state_d = S_IDLE;
            end
            default: begin
                cand_oct_d  = '0;
                cand_note_d = NOTE_NONE;
                stable_d    = '0;
                state_d     = S_IDLE;
            end
        endcase
        if (timeout_pulse) begin
            state_d     = S_IDLE;
            cand_oct_d  = '0;
            cand_note_d = NOTE_NONE;
            stable_d    = '0;
            oct_d       = '0;
            note_d      = NOTE_NONE;
            valid_d     = 1'b0;
            new_d       = 1'b0;
        end
    end
endmodule

// File: tb/tb_tone_decoder.sv
// tb_tone_decoder: directed tone sequences on a time-scaled note table with hand-computed outcomes.
module tb_tone_decoder;
    // Table scaled by 2^-8: A4 = 1818182>>12 = 443 (tol 6), C5 = 3057805>>13 = 373 (tol 5).
    logic clk_100M = 1'b0;
    logic rst_n    = 1'b0;
    logic tone     = 1'b0;
    int   checks   = 0;
    int   errors   = 0;
    int   pulses   = 0;

    tone_decoder_if bus ();
    tone_decoder #(
        .TOL_SHIFT(6), .STABLE_COUNT(2), .TIMEOUT(3000), .MIN_HALF(64), .SCALE_SHIFT(8)
    ) dut (
        .clk_100M(clk_100M),
        .rst_n   (rst_n),
        .tone_in (tone),
        .bus     (bus)
    );

    always #5 clk_100M = ~clk_100M;
    always @(negedge clk_100M) if (bus.new_note === 1'b1) pulses++;

    // Edge now, then hold for m cycles: the next edge measures H = m.
    task automatic half(input int m);
        tone = ~tone;
        repeat (m) @(negedge clk_100M);
    endtask

    task automatic test_reset;
        repeat (4) @(negedge clk_100M);
        checks++; if (bus.valid !== 1'b0 || bus.new_note !== 1'b0) begin errors++; $display("FAIL reset_flags valid=%b new_note=%b want 0/0", bus.valid, bus.new_note); end
        checks++; if ({bus.octave, bus.note} !== 6'd0) begin errors++; $display("FAIL reset_note got %0d/%0d want 0/0", bus.octave, bus.note); end
        rst_n = 1'b1;
        repeat (5) @(negedge clk_100M);
    endtask

    task automatic test_a4;
        half(443);
        half(443);
        checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL a4_one_meas valid=%b want 0", bus.valid); end
        half(443);
        checks++; if ({bus.octave, bus.note} !== {3'd4, 3'd6}) begin errors++; $display("FAIL a4_decode got %0d/%0d want 4/6", bus.octave, bus.note); end
        checks++; if (bus.valid !== 1'b1) begin errors++; $display("FAIL a4_valid got %b want 1", bus.valid); end
        checks++; if (pulses != 1) begin errors++; $display("FAIL a4_pulse got %0d want 1", pulses); end
        repeat (3) half(443);
        checks++; if (pulses != 1 || bus.valid !== 1'b1) begin errors++; $display("FAIL a4_hold pulses=%0d valid=%b want 1/1", pulses, bus.valid); end
    endtask

    task automatic test_switch;
        half(373);
        half(373);
        checks++; if ({bus.octave, bus.note} !== {3'd4, 3'd6}) begin errors++; $display("FAIL c5_early got %0d/%0d want 4/6", bus.octave, bus.note); end
        half(373);
        checks++; if ({bus.octave, bus.note} !== {3'd5, 3'd1}) begin errors++; $display("FAIL c5_decode got %0d/%0d want 5/1", bus.octave, bus.note); end
        checks++; if (pulses != 2) begin errors++; $display("FAIL c5_pulse got %0d want 2", pulses); end
        half(447);
        half(447);
        checks++; if ({bus.octave, bus.note} !== {3'd5, 3'd1}) begin errors++; $display("FAIL a4p1_early got %0d/%0d want 5/1", bus.octave, bus.note); end
        half(447);
        checks++; if ({bus.octave, bus.note} !== {3'd4, 3'd6} || pulses != 3) begin errors++; $display("FAIL a4p1_decode got %0d/%0d pulses %0d want 4/6 pulses 3", bus.octave, bus.note, pulses); end
    endtask

    task automatic test_stray;
        half(443);
        half(373);
        half(443);
        checks++; if ({bus.octave, bus.note} !== {3'd4, 3'd6} || pulses != 3) begin errors++; $display("FAIL stray_c5 got %0d/%0d pulses %0d want 4/6 pulses 3", bus.octave, bus.note, pulses); end
        half(443);
        half(443);
        checks++; if ({bus.octave, bus.note} !== {3'd4, 3'd6} || bus.valid !== 1'b1 || pulses != 3) begin errors++; $display("FAIL stray_after got %0d/%0d v%b pulses %0d want 4/6 v1 pulses 3", bus.octave, bus.note, bus.valid, pulses); end
    endtask

    task automatic test_miss_hold;
        repeat (3) half(460);
        checks++; if ({bus.octave, bus.note} !== {3'd4, 3'd6} || bus.valid !== 1'b1 || pulses != 3) begin errors++; $display("FAIL miss_hold got %0d/%0d v%b pulses %0d want 4/6 v1 pulses 3", bus.octave, bus.note, bus.valid, pulses); end
    endtask

    task automatic test_glitch;
        repeat (3) half(443);
        half(50);
        half(443);
        checks++; if ({bus.octave, bus.note} !== {3'd4, 3'd6} || pulses != 3) begin errors++; $display("FAIL glitch_reject got %0d/%0d pulses %0d want 4/6 pulses 3", bus.octave, bus.note, pulses); end
        half(443);
        half(443);
        checks++; if ({bus.octave, bus.note} !== {3'd4, 3'd6} || bus.valid !== 1'b1 || pulses != 3) begin errors++; $display("FAIL glitch_recover got %0d/%0d v%b pulses %0d want 4/6 v1 pulses 3", bus.octave, bus.note, bus.valid, pulses); end
    endtask

    task automatic test_timeout;
        repeat (2400) @(negedge clk_100M);
        checks++; if (bus.valid !== 1'b1) begin errors++; $display("FAIL timeout_early valid=%b want 1", bus.valid); end
        repeat (250) @(negedge clk_100M);
        checks++; if (bus.valid !== 1'b0 || {bus.octave, bus.note} !== 6'd0) begin errors++; $display("FAIL timeout_clear v%b %0d/%0d want v0 0/0", bus.valid, bus.octave, bus.note); end
        checks++; if (pulses != 3) begin errors++; $display("FAIL timeout_pulse got %0d want 3", pulses); end
        repeat (3) half(460);
        half(443);
        checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL off_tol_decoded valid=%b want 0", bus.valid); end
        half(443);
        checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL restart_one_meas valid=%b want 0", bus.valid); end
        half(443);
        checks++; if ({bus.octave, bus.note} !== {3'd4, 3'd6} || bus.valid !== 1'b1 || pulses != 4) begin errors++; $display("FAIL restart_decode got %0d/%0d v%b pulses %0d want 4/6 v1 pulses 4", bus.octave, bus.note, bus.valid, pulses); end
    endtask

    task automatic test_reset_mid_search;
        if (!tone) half(443);
        tone = ~tone;
        repeat (10) @(negedge clk_100M);
        checks++; if (bus.valid !== 1'b1) begin errors++; $display("FAIL pre_reset valid=%b want 1", bus.valid); end
        rst_n = 1'b0;
        #1;
        checks++; if (bus.valid !== 1'b0 || {bus.octave, bus.note} !== 6'd0 || bus.new_note !== 1'b0) begin errors++; $display("FAIL async_reset v%b %0d/%0d n%b want all 0", bus.valid, bus.octave, bus.note, bus.new_note); end
        repeat (3) @(negedge clk_100M);
        rst_n = 1'b1;
        repeat (5) @(negedge clk_100M);
        half(443);
        half(443);
        checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL post_reset_arm valid=%b want 0", bus.valid); end
        half(443);
        checks++; if ({bus.octave, bus.note} !== {3'd4, 3'd6} || bus.valid !== 1'b1 || pulses != 5) begin errors++; $display("FAIL post_reset_decode got %0d/%0d v%b pulses %0d want 4/6 v1 pulses 5", bus.octave, bus.note, bus.valid, pulses); end
    endtask

    initial begin
        test_reset;
        test_a4;
        test_switch;
        test_stray;
        test_miss_hold;
        test_glitch;
        test_timeout;
        test_reset_mid_search;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
